// File: rtl/regfile_sb.sv
// Multi-port integer register file with write-to-read bypass, a pending-write
// scoreboard for RAW stall detection and a registered debug snapshot.
module regfile_sb #(
  parameter int          XLEN    = 32,
  parameter int          NREGS   = 32,
  parameter int          NRD     = 2,
  parameter int          NWB     = 2,
  parameter int unsigned SP_INIT = 2048,
  localparam int         AW      = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic [NRD*AW-1:0]      rs_addr,
  output logic [NRD*XLEN-1:0]    rs_data,
  output logic [NRD-1:0]         rs_busy,
  input  logic                   rsv_valid,
  input  logic [AW-1:0]          rsv_addr,
  input  logic [NWB-1:0]         wb_valid,
  input  logic [NWB*AW-1:0]      wb_addr,
  input  logic [NWB*XLEN-1:0]    wb_data,
  output logic [AW:0]            busy_cnt,
  output logic [NREGS*XLEN-1:0]  regs_out
);

  logic [XLEN-1:0]  regs     [NREGS];
  logic [XLEN-1:0]  regs_nxt [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [NREGS-1:0] wb_hit;
  logic [AW:0]      cnt_nxt;
  logic [AW-1:0]    ra;
  logic [XLEN-1:0]  rd_v;
  logic             rb;

  function automatic logic [XLEN-1:0] init_val(input int unsigned r);
    return (r == 2) ? XLEN'(SP_INIT) : '0;
  endfunction

  // Read ports: ascending scan over writeback ports so the youngest hit wins.
  always_comb begin
    rs_data = '0;
    rs_busy = '0;
    ra      = '0;
    rd_v    = '0;
    rb      = 1'b0;
    for (int unsigned i = 0; i < NRD; i++) begin
      ra = rs_addr[i*AW +: AW];
      if (!rst && rd_en) begin
        rd_v = regs[ra];
        rb   = busy[ra];
        for (int unsigned j = 0; j < NWB; j++) begin
          if (wb_valid[j] && (ra != '0) && (wb_addr[j*AW +: AW] == ra)) begin
            rd_v = wb_data[j*XLEN +: XLEN];
            rb   = 1'b0;
          end
        end
        rs_data[i*XLEN +: XLEN] = rd_v;
        rs_busy[i]              = rb;
      end
    end
  end

  always_comb begin
    wb_hit = '0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      for (int unsigned j = 0; j < NWB; j++) begin
        if (wb_valid[j] && (wb_addr[j*AW +: AW] == AW'(r))) wb_hit[r] = 1'b1;
      end
    end
  end

  always_comb begin
    regs_nxt = regs;
    busy_nxt = busy;
    cnt_nxt  = '0;
    for (int unsigned j = 0; j < NWB; j++) begin
      if (wb_valid[j] && (wb_addr[j*AW +: AW] != '0))
        regs_nxt[wb_addr[j*AW +: AW]] = wb_data[j*XLEN +: XLEN];
    end
    // A reservation outranks a same-cycle writeback: the new producer is still pending.
    for (int unsigned r = 1; r < NREGS; r++) begin
      if (rsv_valid && (rsv_addr == AW'(r))) busy_nxt[r] = 1'b1;
      else if (wb_hit[r])                    busy_nxt[r] = 1'b0;
    end
    busy_nxt[0] = 1'b0;
    for (int unsigned r = 0; r < NREGS; r++) cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[r]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        regs[r]                   <= init_val(r);
        regs_out[r*XLEN +: XLEN]  <= init_val(r);
      end
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        regs[r]                  <= regs_nxt[r];
        regs_out[r*XLEN +: XLEN] <= regs[r];
      end
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule
